// File: rtl/dino_score_if.sv
// Score bus between the game FSM / collision detector and the score tracker.
// The tracker side is the slave: it consumes state/collision and drives every score output.
interface dino_score_if;
  logic [1:0] state;
  logic       collision_detect;
  logic [6:0] score;
  logic [6:0] disp_score;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] high_score;
  logic       score_tick;
  logic       new_high;

  modport master (
    output state, collision_detect,
    input  score, disp_score, bcd_tens, bcd_ones, high_score, score_tick, new_high
  );

  modport slave (
    input  state, collision_detect,
    output score, disp_score, bcd_tens, bcd_ones, high_score, score_tick, new_high
  );
endinterface

// File: rtl/dino_score_tracker.sv
// Score producer for the dino runner: prescaled score counting, BCD display digits,
// crash reporting to the game FSM and a session high score.
module dino_score_tracker #(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned WIN_SCORE  = 99,
  parameter int unsigned CRASH_CODE = 127
) (
  input logic         clk,
  input logic         reset,
  dino_score_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    SCORE_MAX  = 7'(WIN_SCORE);
  localparam logic [6:0]    CRASH_VAL  = 7'(CRASH_CODE);

  logic [PW-1:0] r_presc;
  logic          r_crashed;
  state_t        r_prev_state;
  logic [6:0]    r_score;
  logic [6:0]    r_disp_score;
  logic [3:0]    r_bcd_tens;
  logic [3:0]    r_bcd_ones;
  logic [6:0]    r_high_score;
  logic          r_score_tick;
  logic          r_new_high;

  state_t w_state;
  logic   w_wrap;
  logic   w_can_inc;
  logic   w_leave_run;

  assign w_state     = state_t'(bus.state);
  assign w_wrap      = (r_presc == PRESC_LAST);
  assign w_can_inc   = (r_disp_score < SCORE_MAX);
  assign w_leave_run = (r_prev_state == ST_RUN) && (w_state != ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the high-score compare below relies on seeing the pre-clear score.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_crashed    <= 1'b0;
      r_prev_state <= ST_IDLE;
      r_score      <= '0;
      r_disp_score <= '0;
      r_bcd_tens   <= '0;
      r_bcd_ones   <= '0;
      r_high_score <= '0;
      r_score_tick <= 1'b0;
      r_new_high   <= 1'b0;
    end else begin
      r_prev_state <= w_state;
      r_score_tick <= 1'b0;
      r_new_high   <= 1'b0;

      if (w_leave_run && (r_disp_score > r_high_score)) begin
        r_high_score <= r_disp_score;
        r_new_high   <= 1'b1;
      end

      case (w_state)
        ST_IDLE: begin
          r_presc      <= '0;
          r_crashed    <= 1'b0;
          r_score      <= '0;
          r_disp_score <= '0;
          r_bcd_tens   <= '0;
          r_bcd_ones   <= '0;
        end
        ST_RUN: begin
          if (!r_crashed) begin
            // A collision beats a coincident prescaler wrap: no point is awarded.
            if (bus.collision_detect) begin
              r_crashed <= 1'b1;
              r_score   <= CRASH_VAL;
            end else begin
              r_presc <= w_wrap ? '0 : r_presc + PW'(1);
              if (w_wrap && w_can_inc) begin
                r_score      <= r_score + 7'd1;
                r_disp_score <= r_disp_score + 7'd1;
                r_score_tick <= 1'b1;
                if (r_bcd_ones == 4'd9) begin
                  r_bcd_ones <= 4'd0;
                  r_bcd_tens <= r_bcd_tens + 4'd1;
                end else begin
                  r_bcd_ones <= r_bcd_ones + 4'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.score      = r_score;
  assign bus.disp_score = r_disp_score;
  assign bus.bcd_tens   = r_bcd_tens;
  assign bus.bcd_ones   = r_bcd_ones;
  assign bus.high_score = r_high_score;
  assign bus.score_tick = r_score_tick;
  assign bus.new_high   = r_new_high;

endmodule

// File: tb/tb_dino_score_tracker.sv
// Scoreboard bench for dino_score_tracker: directed game sessions followed by random play,
// each cycle's expected outputs come from a run-count based reference model.
module tb_dino_score_tracker;

  localparam int TD    = 4;
  localparam int WIN   = 99;
  localparam int CRASH = 127;
  localparam int S_IDLE = 0, S_RUN = 1, S_WIN = 2, S_OVER = 3;

  typedef struct {
    int score;
    int disp;
    int tens;
    int ones;
    int high;
    int tick;
    int nh;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  dino_score_if bus();

  dino_score_tracker #(.TICK_DIV(TD), .WIN_SCORE(WIN), .CRASH_CODE(CRASH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  // Reference model: score is simply completed RUN cycles / TICK_DIV, capped at WIN.
  int m_run_cycles = 0;
  int m_disp       = 0;
  int m_crashed    = 0;
  int m_high       = 0;
  int m_prev       = S_IDLE;

  task automatic check(input string name, input int act, input int expv, input int at);
    n_vec++;
    if (act != expv) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, at, act, expv);
    end
  endtask

  task automatic model_edge(input int st, input int col, input int rs);
    exp_t e;
    e.tick = 0;
    e.nh   = 0;
    if (rs) begin
      m_run_cycles = 0; m_disp = 0; m_crashed = 0; m_high = 0; m_prev = S_IDLE;
    end else begin
      if (m_prev == S_RUN && st != S_RUN && m_disp > m_high) begin
        m_high = m_disp;
        e.nh   = 1;
      end
      m_prev = st;
      if (st == S_IDLE) begin
        m_run_cycles = 0; m_disp = 0; m_crashed = 0;
      end else if (st == S_RUN && !m_crashed) begin
        if (col) m_crashed = 1;
        else begin
          m_run_cycles++;
          if (m_run_cycles % TD == 0 && m_disp < WIN) begin
            m_disp++;
            e.tick = 1;
          end
        end
      end
    end
    e.disp  = m_disp;
    e.score = m_crashed ? CRASH : m_disp;
    e.tens  = m_disp / 10;
    e.ones  = m_disp % 10;
    e.high  = m_high;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step(input int st, input int col, input int rs);
    @(negedge clk);
    bus.state            = 2'(st);
    bus.collision_detect = col[0];
    reset                = rs[0];
    @(posedge clk);
    cyc++;
    model_edge(st, col, rs);
  endtask

  task automatic run_for(input int st, input int n, input int col);
    for (int i = 0; i < n; i++) step(st, col, 0);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("score",      int'(bus.score),      e.score, e.cyc);
      check("disp_score", int'(bus.disp_score), e.disp,  e.cyc);
      check("bcd_tens",   int'(bus.bcd_tens),   e.tens,  e.cyc);
      check("bcd_ones",   int'(bus.bcd_ones),   e.ones,  e.cyc);
      check("high_score", int'(bus.high_score), e.high,  e.cyc);
      check("score_tick", int'(bus.score_tick), e.tick,  e.cyc);
      check("new_high",   int'(bus.new_high),   e.nh,    e.cyc);
    end
  end

  initial begin
    int st;
    bus.state            = 2'd0;
    bus.collision_detect = 1'b0;
    reset                = 1'b1;

    // Reset then IDLE
    for (int i = 0; i < 3; i++) step(S_IDLE, 0, 1);
    run_for(S_IDLE, 5, 0);

    // Counting, then saturation with BCD carries, then WIN latches the high score
    run_for(S_RUN, 12, 0);
    run_for(S_RUN, 400, 0);
    run_for(S_WIN, 3, 0);
    run_for(S_IDLE, 2, 0);

    // Collision at disp_score 5, further collisions, collisions outside RUN
    run_for(S_RUN, 20, 0);
    step(S_RUN, 1, 0);
    run_for(S_RUN, 3, 1);
    run_for(S_RUN, 6, 0);
    run_for(S_OVER, 2, 1);
    run_for(S_IDLE, 2, 1);
    run_for(S_WIN, 2, 1);
    run_for(S_IDLE, 2, 0);

    // Collision coincident with a prescaler wrap
    run_for(S_RUN, 2 * TD - 1, 0);
    step(S_RUN, 1, 0);
    run_for(S_RUN, 4, 0);
    run_for(S_OVER, 2, 0);

    // High-score sessions after a fresh reset: 7, 7 again, then 3
    step(S_IDLE, 0, 1);
    run_for(S_IDLE, 2, 0);
    run_for(S_RUN, 7 * TD, 0);  run_for(S_OVER, 2, 0); run_for(S_IDLE, 2, 0);
    run_for(S_RUN, 7 * TD, 0);  run_for(S_OVER, 2, 0); run_for(S_IDLE, 2, 0);
    run_for(S_RUN, 3 * TD, 0);  run_for(S_OVER, 2, 0); run_for(S_IDLE, 3, 0);

    // Reset mid-RUN at score 12, then count again from zero
    run_for(S_RUN, 12 * TD, 0);
    step(S_RUN, 0, 1);
    run_for(S_RUN, 3 * TD + 1, 0);
    run_for(S_IDLE, 2, 0);

    // Random play including illegal RUN->IDLE paths and rare resets
    st = S_IDLE;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) st = int'($urandom_range(0, 3));
      step(st, ($urandom_range(0, 39) == 0) ? 1 : 0, ($urandom_range(0, 499) == 0) ? 1 : 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_vec++;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
